// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multi-cycle datapath memory stall bridge.
package mips_mem_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

    // Bridge control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Command presented to memory for the duration of one request
    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] adr;
        logic [WORD_W-1:0] wdata;
    } mem_cmd_t;

    // Word accesses must have both byte-offset bits clear
    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait counter for an outstanding memory request; flags the last allowed cycle.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count waited cycles; saturate at the expiry value so it never wraps
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stall_bridge.sv
// Stalls a multi-cycle datapath while a single memory access completes or times out.
module mem_stall_bridge
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] cpu_adr,
    input  logic [WORD_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_adr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    mem_state_e        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              req_q, req_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              cnt_clear, cnt_en, cnt_expired;
    logic              access;

    assign access = cpu_read | cpu_write;

    // Request wait counter, restarted on every REQ entry and on reset
    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .clear   (rst | cnt_clear),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    // Next state, next registered outputs and the combinational stall
    always_comb begin
        state_d   = state_q;
        req_d     = 1'b0;
        cmd_d     = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        cpu_stall = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    cpu_stall = 1'b1;
                    if (is_word_aligned(cpu_adr[1:0])) begin
                        // A simultaneous read and write is treated as a write
                        state_d     = ST_REQ;
                        req_d       = 1'b1;
                        cmd_d.we    = cpu_write;
                        cmd_d.adr   = {cpu_adr[WORD_W-1:2], 2'b00};
                        cmd_d.wdata = cpu_wdata;
                        cnt_clear   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_REQ: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    if (!cmd_q.we) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_expired) begin
                    err_d = 1'b1;
                    if (!cmd_q.we) begin
                        rdata_d = '0;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_en  = 1'b1;
                    req_d   = 1'b1;
                    cmd_d   = cmd_q;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = cmd_q.we;
    assign mem_adr   = cmd_q.adr;
    assign mem_wdata = cmd_q.wdata;
    assign cpu_rdata = rdata_q;
    assign err       = err_q;

endmodule
